// File: rtl/meas_sequencer.sv
// -----------------------------------------------------------------------------
// meas_sequencer
//
// Measurement scheduler for the clk_512k domain. After an accepted start it
// optionally runs one SPI chip-configuration pass, then runs n_rep repetitions
// of the DAC/ADC task. Repetitions are separated by t_gap idle cycles. After
// each repetition a force_flip pulse tells the ADC ping-pong FIFO to swap
// buffers, so the host sees one buffer per repetition. A repetition does not
// start while the ping-pong FIFO reports full.
//
// Optional build macro: MEAS_SEQ_TIMEOUT_EN
//   defined   : a wait-state watchdog (limit t_timeout, 0 = off) sets the
//               sticky seq_err flag and abandons the sequence.
//   undefined : no watchdog, seq_err is tied low, t_timeout is ignored.
//
// Ports
//   clk            clock (clk_512k)
//   rst            asynchronous reset, active low
//   start          begin a sequence (only honoured when idle)
//   abort          synchronous abort back to idle, highest priority
//   cfg_en         run the SPI configuration pass first (sampled at start)
//   n_rep          repetition count, 0 treated as 1 (sampled at start)
//   t_gap          idle cycles between repetitions (sampled at start)
//   t_timeout      watchdog limit in cycles (sampled at start)
//   done_spi       SPI FSM done, rising edge used
//   done_task      task FSM done, rising edge used
//   full_ppfifo    ping-pong FIFO full
//   trigger_config one-cycle pulse to the SPI FSM
//   trigger_task   one-cycle pulse to the task FSM
//   force_flip     one-cycle pulse to the ping-pong FIFO
//   busy           high whenever the sequencer is not idle
//   seq_done       one-cycle pulse on normal completion
//   seq_err        sticky watchdog flag, cleared by the next accepted start
//   rep_cnt        repetitions completed in the current sequence
// -----------------------------------------------------------------------------
module meas_sequencer #(
    parameter int REP_W  = 16,
    parameter int TIME_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_en,
    input  logic [REP_W-1:0]  n_rep,
    input  logic [TIME_W-1:0] t_gap,
    input  logic [TIME_W-1:0] t_timeout,
    input  logic              done_spi,
    input  logic              done_task,
    input  logic              full_ppfifo,
    output logic              trigger_config,
    output logic              trigger_task,
    output logic              force_flip,
    output logic              busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [REP_W-1:0]  rep_cnt
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CFG_TRIG  = 4'd1,
        ST_CFG_WAIT  = 4'd2,
        ST_READY     = 4'd3,
        ST_TASK_TRIG = 4'd4,
        ST_TASK_WAIT = 4'd5,
        ST_FLIP      = 4'd6,
        ST_GAP       = 4'd7,
        ST_FINISH    = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [REP_W-1:0]  n_rep_q, n_rep_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [TIME_W-1:0] t_gap_q, t_gap_d;
    logic [TIME_W-1:0] gap_cnt_q, gap_cnt_d;

    // One register stage on each done input, plus the previous sample, so an
    // event is a clean low-to-high transition seen in this clock domain.
    logic spi_sync_q, spi_prev_q;
    logic task_sync_q, task_prev_q;
    logic spi_evt, task_evt;

    assign spi_evt  = spi_sync_q  & ~spi_prev_q;
    assign task_evt = task_sync_q & ~task_prev_q;

`ifdef MEAS_SEQ_TIMEOUT_EN
    logic [TIME_W-1:0] t_timeout_q, t_timeout_d;
    logic [TIME_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              seq_err_q, seq_err_d;
    logic              wait_expired;

    // wait_cnt_q is 0 in the first wait cycle, so expiry after exactly
    // t_timeout wait cycles is the cycle where the count is t_timeout-1.
    assign wait_expired = (t_timeout_q != '0) && (wait_cnt_q == t_timeout_q - TIME_W'(1));
    assign seq_err      = seq_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^t_timeout;
    assign seq_err        = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        n_rep_d        = n_rep_q;
        rep_cnt_d      = rep_cnt_q;
        t_gap_d        = t_gap_q;
        gap_cnt_d      = gap_cnt_q;
        trigger_config = 1'b0;
        trigger_task   = 1'b0;
        force_flip     = 1'b0;
        seq_done       = 1'b0;
`ifdef MEAS_SEQ_TIMEOUT_EN
        t_timeout_d    = t_timeout_q;
        wait_cnt_d     = wait_cnt_q;
        seq_err_d      = seq_err_q;
`endif
        if (abort) begin
            // Everything else (rep_cnt, seq_err) holds; pulses stay low.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_rep_d   = (n_rep == '0) ? REP_W'(1) : n_rep;
                        t_gap_d   = t_gap;
                        rep_cnt_d = '0;
`ifdef MEAS_SEQ_TIMEOUT_EN
                        t_timeout_d = t_timeout;
                        seq_err_d   = 1'b0;
`endif
                        state_d   = cfg_en ? ST_CFG_TRIG : ST_READY;
                    end
                end
                ST_CFG_TRIG: begin
                    trigger_config = 1'b1;
`ifdef MEAS_SEQ_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                    state_d = ST_CFG_WAIT;
                end
                ST_CFG_WAIT: begin
                    if (spi_evt) begin
                        state_d = ST_READY;
`ifdef MEAS_SEQ_TIMEOUT_EN
                    end else if (wait_expired) begin
                        seq_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TIME_W'(1);
`endif
                    end
                end
                ST_READY: begin
                    if (!full_ppfifo) begin
                        state_d = ST_TASK_TRIG;
                    end
                end
                ST_TASK_TRIG: begin
                    trigger_task = 1'b1;
`ifdef MEAS_SEQ_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                    state_d = ST_TASK_WAIT;
                end
                ST_TASK_WAIT: begin
                    if (task_evt) begin
                        state_d = ST_FLIP;
`ifdef MEAS_SEQ_TIMEOUT_EN
                    end else if (wait_expired) begin
                        seq_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TIME_W'(1);
`endif
                    end
                end
                ST_FLIP: begin
                    force_flip = 1'b1;
                    rep_cnt_d  = rep_cnt_q + REP_W'(1);
                    if (rep_cnt_d == n_rep_q) begin
                        state_d = ST_FINISH;
                    end else if (t_gap_q == '0) begin
                        state_d = ST_READY;
                    end else begin
                        gap_cnt_d = t_gap_q - TIME_W'(1);
                        state_d   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = ST_READY;
                    end else begin
                        gap_cnt_d = gap_cnt_q - TIME_W'(1);
                    end
                end
                ST_FINISH: begin
                    seq_done = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            n_rep_q     <= '0;
            rep_cnt_q   <= '0;
            t_gap_q     <= '0;
            gap_cnt_q   <= '0;
            spi_sync_q  <= 1'b0;
            spi_prev_q  <= 1'b0;
            task_sync_q <= 1'b0;
            task_prev_q <= 1'b0;
`ifdef MEAS_SEQ_TIMEOUT_EN
            t_timeout_q <= '0;
            wait_cnt_q  <= '0;
            seq_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            n_rep_q     <= n_rep_d;
            rep_cnt_q   <= rep_cnt_d;
            t_gap_q     <= t_gap_d;
            gap_cnt_q   <= gap_cnt_d;
            spi_sync_q  <= done_spi;
            spi_prev_q  <= spi_sync_q;
            task_sync_q <= done_task;
            task_prev_q <= task_sync_q;
`ifdef MEAS_SEQ_TIMEOUT_EN
            t_timeout_q <= t_timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            seq_err_q   <= seq_err_d;
`endif
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign rep_cnt = rep_cnt_q;

endmodule
